// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   arb_state_t : FSM encoding (IDLE=0, SEND=1, HOLD=2, DRAIN=3)
//   DEF_DATA_W  : default byte width
//   clog2()     : ceiling log2, also usable by the UART baud/divider logic
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_t;

    localparam int DEF_DATA_W = 8;

    // Smallest r with 2**r >= value; written as a bounded loop so it
    // elaborates cleanly as a constant function.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
//   req   : request vector, one bit per requester
//   ptr   : index with highest priority; search proceeds upward and wraps
//   found : at least one request bit is set
//   index : first set request at or after ptr
module uart_tx_arbiter_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    index
);

    // base is always a legal requester index, so a single subtraction wraps.
    function automatic logic [ID_W-1:0] wrap(input logic [ID_W-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return ID_W'(s);
    endfunction

    // Scan from the farthest candidate back toward ptr so the nearest hit
    // is the last assignment and wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[wrap(ptr, k)]) begin
                found = 1'b1;
                index = wrap(ptr, k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter feeding one UART transmitter.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   req_valid/req_data/req_last : per-requester byte stream inputs
//   req_ready    : one-hot accept strobe, owner only, while in SEND
//   tx_data/tx_start : registered byte and start pulse to the transmitter
//   tx_busy      : transmitter busy, high from the cycle after tx_start
//   grant_id/grant_active : current owner and grant-held flag
// A grant is held until the owner sends a byte flagged last or MAX_PKT
// bytes have gone out; the released requester then drops to lowest priority.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MAX_PKT = 16,
    localparam int ID_W   = clog2(NUM_REQ)
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      grant_active
);

    localparam logic [7:0] PKT_LIMIT = 8'(MAX_PKT);

    arb_state_t        state;
    logic [ID_W-1:0]   rr_ptr;
    logic [7:0]        byte_cnt;
    logic              last_q;

    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;
    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    logic              accept;
    logic [ID_W-1:0]   next_ptr;

    uart_tx_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .index (pick_idx)
    );

    // Owner's byte stream; non-owners are never looked at.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign accept   = (state == ST_SEND) && sel_valid && !tx_busy;
    assign next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            byte_cnt     <= '0;
            last_q       <= 1'b0;
            grant_id     <= '0;
            grant_active <= 1'b0;
            tx_start     <= 1'b0;
            tx_data      <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_id     <= pick_idx;
                        grant_active <= 1'b1;
                        byte_cnt     <= '0;
                        state        <= ST_SEND;
                    end
                end
                // An owner with no byte ready keeps the grant and stalls here.
                ST_SEND: begin
                    if (accept) begin
                        tx_data  <= sel_data;
                        tx_start <= 1'b1;
                        last_q   <= sel_last;
                        byte_cnt <= byte_cnt + 8'd1;
                        state    <= ST_HOLD;
                    end
                end
                // tx_busy only rises the cycle after tx_start, so skip one
                // cycle before trusting it.
                ST_HOLD: begin
                    state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!tx_busy) begin
                        if (last_q || (byte_cnt == PKT_LIMIT)) begin
                            rr_ptr       <= next_ptr;
                            grant_active <= 1'b0;
                            state        <= ST_IDLE;
                        end else begin
                            state <= ST_SEND;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
